// File: rtl/bram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter_if
//   Bundles every requester handshake and the BRAM port of the data-memory
//   arbiter into one interface.
//
//   Requester side (cpu / vid / io, one set each):
//     *_req    request, held by the requester until its ack
//     *_we     1 = write, 0 = read
//     *_addr   word address   (ADDR_W)
//     *_wdata  write data     (DATA_W)
//     *_ack    one-cycle completion pulse
//     rdata    read data, valid in the ack cycle, held until the next read
//   BRAM side:
//     mem_en, mem_we, mem_addr, mem_wdata  driven by the arbiter
//     mem_rdata                            returned by the BRAM
//   Status:
//     busy      high whenever a transaction is in flight
//     grant_id  current winner: 0 = cpu, 1 = vid, 2 = io, 3 = none
//
//   Modports:
//     slave  - the arbiter's view (requests and mem_rdata in)
//     master - the surroundings' view (requesters plus BRAM)
// ---------------------------------------------------------------------------
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req,   vid_req,   io_req;
  logic              cpu_we,    vid_we,    io_we;
  logic [ADDR_W-1:0] cpu_addr,  vid_addr,  io_addr;
  logic [DATA_W-1:0] cpu_wdata, vid_wdata, io_wdata;
  logic              cpu_ack,   vid_ack,   io_ack;
  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic [1:0]        grant_id;

  modport slave (
    input  cpu_req, vid_req, io_req,
    input  cpu_we, vid_we, io_we,
    input  cpu_addr, vid_addr, io_addr,
    input  cpu_wdata, vid_wdata, io_wdata,
    input  mem_rdata,
    output cpu_ack, vid_ack, io_ack,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, grant_id
  );

  modport master (
    output cpu_req, vid_req, io_req,
    output cpu_we, vid_we, io_we,
    output cpu_addr, vid_addr, io_addr,
    output cpu_wdata, vid_wdata, io_wdata,
    output mem_rdata,
    input  cpu_ack, vid_ack, io_ack,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, grant_id
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//   Shares the single data-BRAM port between the CPU load/store path, the
//   video renderer read path and the controller/IO writer. One transaction
//   is in flight at a time; reads wait out the BRAM latency and return data
//   together with a one-cycle ack pulse.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    bram_port_arbiter_if.slave (requesters, BRAM port, status)
//
//   Parameters:
//     ADDR_W  BRAM word-address width
//     DATA_W  data width
//     RD_LAT  BRAM read latency in cycles, 1..4
//
//   Build option:
//     ARB_CPU_PRIORITY_EN  when defined the CPU has fixed top priority and
//                          vid/io round-robin between themselves; otherwise
//                          all three requesters share a plain round-robin.
//
//   Timing (cycles counted from the edge that samples req in IDLE):
//     write ack 2 cycles later, read ack 2 + RD_LAT cycles later.
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input logic                clk,
  input logic                reset,
  bram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [1:0] ID_CPU  = 2'd0;
  localparam logic [1:0] ID_VID  = 2'd1;
  localparam logic [1:0] ID_IO   = 2'd2;
  localparam logic [1:0] ID_NONE = 2'd3;
  localparam logic [2:0] LAT     = 3'(RD_LAT);

  state_t     state;
  logic [1:0] last_grant;
  logic [2:0] wait_cnt;
  logic [2:0] ack;
  logic [2:0] req;
  logic [1:0] winner;

  assign req         = {bus.io_req, bus.vid_req, bus.cpu_req};
  assign bus.cpu_ack = ack[0];
  assign bus.vid_ack = ack[1];
  assign bus.io_ack  = ack[2];

  // One-hot ack pattern for a requester id.
  function automatic logic [2:0] ack_mask(input logic [1:0] id);
    return 3'b001 << id;
  endfunction

  // Winner selection. last_grant is the requester served most recently, so
  // the search starts one position after it.
  always_comb begin
    // NOTE: winner gets a default before any branch, so every path through
    // this block assigns it and no latch is inferred.
    winner = ID_NONE;
`ifdef ARB_CPU_PRIORITY_EN
    // CPU always wins; last_grant only tracks vid/io in this build, so the
    // two of them alternate.
    if (req[0]) begin
      winner = ID_CPU;
    end else if (last_grant == ID_VID) begin
      if      (req[2]) winner = ID_IO;
      else if (req[1]) winner = ID_VID;
    end else begin
      if      (req[1]) winner = ID_VID;
      else if (req[2]) winner = ID_IO;
    end
`else
    case (last_grant)
      ID_CPU: begin
        if      (req[1]) winner = ID_VID;
        else if (req[2]) winner = ID_IO;
        else if (req[0]) winner = ID_CPU;
      end
      ID_VID: begin
        if      (req[2]) winner = ID_IO;
        else if (req[0]) winner = ID_CPU;
        else if (req[1]) winner = ID_VID;
      end
      default: begin
        if      (req[0]) winner = ID_CPU;
        else if (req[1]) winner = ID_VID;
        else if (req[2]) winner = ID_IO;
      end
    endcase
`endif
  end

  // Single FSM; every output it drives is a register.
  // NOTE: state and registered outputs use non-blocking assignments so all
  // of them update together from the values present before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_grant    <= ID_IO;
      wait_cnt      <= '0;
      ack           <= '0;
      bus.grant_id  <= ID_NONE;
      bus.rdata     <= '0;
      bus.busy      <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (winner != ID_NONE) begin
            state        <= ISSUE;
            bus.busy     <= 1'b1;
            bus.mem_en   <= 1'b1;
            bus.grant_id <= winner;
            // Only the winner's inputs ever reach the BRAM; they stay latched
            // in mem_addr/mem_wdata until the next grant.
            case (winner)
              ID_CPU: begin
                bus.mem_we    <= bus.cpu_we;
                bus.mem_addr  <= bus.cpu_addr;
                bus.mem_wdata <= bus.cpu_wdata;
              end
              ID_VID: begin
                bus.mem_we    <= bus.vid_we;
                bus.mem_addr  <= bus.vid_addr;
                bus.mem_wdata <= bus.vid_wdata;
              end
              default: begin
                bus.mem_we    <= bus.io_we;
                bus.mem_addr  <= bus.io_addr;
                bus.mem_wdata <= bus.io_wdata;
              end
            endcase
          end
        end

        ISSUE: begin
          // The BRAM access happens on this cycle's closing edge.
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          if (bus.mem_we) begin
            state <= ACK;
            ack   <= ack_mask(bus.grant_id);
          end else begin
            state    <= WAIT;
            wait_cnt <= LAT;
          end
        end

        WAIT: begin
          // Read data is valid while the counter sits at 1.
          if (wait_cnt == 3'd1) begin
            state     <= ACK;
            bus.rdata <= bus.mem_rdata;
            ack       <= ack_mask(bus.grant_id);
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        ACK: begin
          state        <= IDLE;
          ack          <= '0;
          bus.busy     <= 1'b0;
          bus.grant_id <= ID_NONE;
`ifdef ARB_CPU_PRIORITY_EN
          if (bus.grant_id != ID_CPU) last_grant <= bus.grant_id;
`else
          last_grant <= bus.grant_id;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
